dvi_tmds_encoder: RTL and testbench

- Sits directly downstream of the video unit, in the pixel clock domain.
- Consumes the video unit's red/green/blue, pixel (display-enable), hsync and vsync outputs and produces three 10-bit TMDS symbols (DVI 1.0 encoding) for a serializer or OSERDES.
- Implements transition-minimised 8b/9b coding, DC balancing with a per-channel running disparity counter, and control-period token insertion.
- Two-stage pipeline, advanced only on the pixel clock enable.

---
 rtl/dvi_tmds_encoder.sv | 156 +++++++++++++++
 tb/tb_dvi_tmds_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three channels of 8b/10b transition-minimised,
// DC-balanced coding with control-token insertion during blanking.
// Two register stages, both advancing only when clk_en_i is high.
//
// Ports:
//   clk_i, rst_ni        pixel clock, asynchronous active-low reset
//   clk_en_i             pixel clock enable
//   red_i/green_i/blue_i pixel colour components
//   de_i                 data enable (active video)
//   hsync_i, vsync_i     syncs, carried as control bits c0/c1 on channel 0
//   tmds_ch0_o..ch2_o    10-bit symbols, bit 0 transmitted first
//   de_o                 de_i delayed to line up with the symbols
module dvi_tmds_encoder #(
  parameter bit SWAP_RB = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_en_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       de_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] tmds_ch0_o,
  output logic [9:0] tmds_ch1_o,
  output logic [9:0] tmds_ch2_o,
  output logic       de_o
);

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  typedef struct packed {
    logic [9:0] sym;
    logic [4:0] cnt;
  } st2_t;

  // 8b -> 9b transition minimisation; q_m[8] = 1 marks the XOR chain.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = 4'($countones(d));
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC balancing. bal is N1 - N0 of the 8 data bits; cnt holds the running
  // disparity of the symbols sent since the last blanking period.
  function automatic st2_t tmds_stage2(input logic [8:0]        q_m,
                                       input logic signed [4:0] cnt,
                                       input logic              de,
                                       input logic [9:0]        token);
    st2_t              r;
    logic [7:0]        q;
    logic              q8;
    logic [3:0]        n1;
    logic signed [5:0] bal;
    logic signed [5:0] c;
    logic signed [5:0] nxt;
    q   = q_m[7:0];
    q8  = q_m[8];
    n1  = 4'($countones(q));
    bal = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    c   = {cnt[4], cnt};
    nxt = '0;
    r.sym = token;
    if (!de) begin
      r.sym = token;
      nxt   = '0;
    end else if ((c == 6'sd0) || (bal == 6'sd0)) begin
      r.sym = {~q8, q8, (q8 ? q : ~q)};
      nxt   = q8 ? (c + bal) : (c - bal);
    end else if (((c > 6'sd0) && (bal > 6'sd0)) || ((c < 6'sd0) && (bal < 6'sd0))) begin
      r.sym = {1'b1, q8, ~q};
      nxt   = c - bal + (q8 ? 6'sd2 : 6'sd0);
    end else begin
      r.sym = {1'b0, q8, q};
      nxt   = c + bal - (q8 ? 6'sd0 : 6'sd2);
    end
    r.cnt = nxt[4:0];
    return r;
  endfunction

  logic [7:0]        data_in [3];
  logic [8:0]        q_m_q   [3];
  logic              de_s1_q;
  logic              c0_s1_q;
  logic              c1_s1_q;
  logic [9:0]        sym_q   [3];
  logic signed [4:0] cnt_q   [3];
  logic              de_s2_q;
  logic [9:0]        tok0;
  st2_t              st2_d   [3];

  assign data_in[0] = SWAP_RB ? red_i  : blue_i;
  assign data_in[1] = green_i;
  assign data_in[2] = SWAP_RB ? blue_i : red_i;

  always_comb begin
    tok0 = TOKEN_00;
    case ({c1_s1_q, c0_s1_q})
      2'b00:   tok0 = TOKEN_00;
      2'b01:   tok0 = TOKEN_01;
      2'b10:   tok0 = TOKEN_10;
      default: tok0 = TOKEN_11;
    endcase
  end

  // Only channel 0 carries sync information in its tokens.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      st2_d[ch] = tmds_stage2(q_m_q[ch], cnt_q[ch], de_s1_q,
                              (ch == 0) ? tok0 : TOKEN_00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ch = 0; ch < 3; ch++) begin
        q_m_q[ch] <= '0;
        sym_q[ch] <= TOKEN_00;
        cnt_q[ch] <= '0;
      end
      de_s1_q <= 1'b0;
      c0_s1_q <= 1'b0;
      c1_s1_q <= 1'b0;
      de_s2_q <= 1'b0;
    end else if (clk_en_i) begin
      for (int ch = 0; ch < 3; ch++) begin
        q_m_q[ch] <= tm_encode(data_in[ch]);
        sym_q[ch] <= st2_d[ch].sym;
        cnt_q[ch] <= st2_d[ch].cnt;
      end
      de_s1_q <= de_i;
      c0_s1_q <= hsync_i;
      c1_s1_q <= vsync_i;
      de_s2_q <= de_s1_q;
    end
  end

  assign tmds_ch0_o = sym_q[0];
  assign tmds_ch1_o = sym_q[1];
  assign tmds_ch2_o = sym_q[2];
  assign de_o       = de_s2_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
module tb_dvi_tmds_encoder;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clk_en_i;
  logic [7:0] red_i, green_i, blue_i;
  logic       de_i, hsync_i, vsync_i;
  logic [9:0] tmds_ch0_o, tmds_ch1_o, tmds_ch2_o;
  logic       de_o;

  dvi_tmds_encoder #(.SWAP_RB(1'b0)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clk_en_i   (clk_en_i),
    .red_i      (red_i),
    .green_i    (green_i),
    .blue_i     (blue_i),
    .de_i       (de_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .tmds_ch0_o (tmds_ch0_o),
    .tmds_ch1_o (tmds_ch1_o),
    .tmds_ch2_o (tmds_ch2_o),
    .de_o       (de_o)
  );

  always #5 clk_i = ~clk_i;

  // sym = {ch2, ch1, ch0}; px = {red, green, blue} (channel order)
  typedef struct packed {
    logic [29:0] sym;
    logic        de;
    logic [23:0] px;
  } exp_t;

  exp_t q_exp[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_disp [3];
  int   dut_disp   [3];

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: each symbol is chosen by the DVI rules, and the running
  // disparity is simply the accumulated (ones - zeros) of the symbols sent.
  function automatic logic [9:0] model_enc(input logic [7:0] d, inout int disp);
    int         ones, bal;
    bit         xnor_mode, inv;
    logic [8:0] qm;
    logic [9:0] s;
    ones      = $countones(d);
    xnor_mode = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0]     = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xnor_mode ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnor_mode;
    bal   = 2 * $countones(qm[7:0]) - 8;
    if (disp == 0 || bal == 0) inv = !qm[8];
    else                       inv = ((disp > 0) == (bal > 0));
    s = {inv, qm[8], (inv ? ~qm[7:0] : qm[7:0])};
    disp += 2 * $countones(s) - 10;
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, b;
    d    = s[9] ? ~s[7:0] : s[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++)
      b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return b;
  endfunction

  function automatic exp_t model_px(input bit de, input bit hs, input bit vs,
                                    input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_t e;
    e.de = de;
    e.px = {r, g, b};
    if (!de) begin
      case ({vs, hs})
        2'b00:   e.sym[9:0] = 10'h354;
        2'b01:   e.sym[9:0] = 10'h0AB;
        2'b10:   e.sym[9:0] = 10'h154;
        default: e.sym[9:0] = 10'h2AB;
      endcase
      e.sym[29:10] = {10'h354, 10'h354};
      for (int ch = 0; ch < 3; ch++) model_disp[ch] = 0;
    end else begin
      e.sym[9:0]   = model_enc(b, model_disp[0]);
      e.sym[19:10] = model_enc(g, model_disp[1]);
      e.sym[29:20] = model_enc(r, model_disp[2]);
    end
    return e;
  endfunction

  // Pipeline contents right after reset: stage 1 holds de=0, c=00.
  task automatic seed_after_reset();
    exp_t e;
    q_exp.delete();
    for (int ch = 0; ch < 3; ch++) begin
      model_disp[ch] = 0;
      dut_disp[ch]   = 0;
    end
    e.sym = {10'h354, 10'h354, 10'h354};
    e.de  = 1'b0;
    e.px  = '0;
    q_exp.push_back(e);
    last_exp = e;
  endtask

  task automatic drive(input bit en, input bit de, input bit hs, input bit vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk_i);
    clk_en_i = en; de_i = de; hsync_i = hs; vsync_i = vs;
    red_i = r; green_i = g; blue_i = b;
    if (en) q_exp.push_back(model_px(de, hs, vs, r, g, b));
  endtask

  // Monitor: one expected entry per enabled edge; disabled edges must hold.
  initial begin
    bit         en, rs;
    exp_t       e;
    logic [9:0] s [3];
    forever begin
      @(posedge clk_i);
      en = clk_en_i;
      rs = rst_ni;
      #1;
      if (rs === 1'b1) begin
        s[0] = tmds_ch0_o; s[1] = tmds_ch1_o; s[2] = tmds_ch2_o;
        if (en) begin
          if (q_exp.size() == 0) begin
            chk("underflow", 1'b0, 32'd0, 32'd1);
          end else begin
            e = q_exp.pop_front();
            last_exp = e;
            chk("symbols", {s[2], s[1], s[0]} === e.sym, {2'b0, s[2], s[1], s[0]}, {2'b0, e.sym});
            chk("de_o", de_o === e.de, {31'd0, de_o}, {31'd0, e.de});
            if (e.de) begin
              for (int ch = 0; ch < 3; ch++) begin
                chk("decode", decode(s[ch]) === e.px[ch*8 +: 8],
                    {24'd0, decode(s[ch])}, {24'd0, e.px[ch*8 +: 8]});
                dut_disp[ch] += 2 * $countones(s[ch]) - 10;
                chk("disparity_bound", dut_disp[ch] >= -8 && dut_disp[ch] <= 8,
                    dut_disp[ch], 32'd8);
              end
            end else begin
              for (int ch = 0; ch < 3; ch++) dut_disp[ch] = 0;
            end
          end
        end else begin
          chk("hold", {s[2], s[1], s[0]} === last_exp.sym && de_o === last_exp.de,
              {1'b0, de_o, s[2], s[1], s[0]}, {1'b0, last_exp.de, last_exp.sym});
        end
      end
    end
  end

  initial begin
    int pos;
    rst_ni = 1'b0; clk_en_i = 1'b0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    red_i = '0; green_i = '0; blue_i = '0;
    #23;
    chk("reset_ch0", tmds_ch0_o === 10'h354, {22'd0, tmds_ch0_o}, 32'h354);
    chk("reset_ch1", tmds_ch1_o === 10'h354, {22'd0, tmds_ch1_o}, 32'h354);
    chk("reset_ch2", tmds_ch2_o === 10'h354, {22'd0, tmds_ch2_o}, 32'h354);
    chk("reset_de",  de_o === 1'b0, {31'd0, de_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seed_after_reset();

    // Control tokens with hsync=1
    repeat (4) drive(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    // Two black pixels after blanking: 100 then 3FF
    repeat (2) drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) drive(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // Blue FF then 00: second symbol takes the inversion branch
    drive(1, 1, 0, 0, 8'h00, 8'h00, 8'hFF);
    drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) drive(1, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    // Clock enable gaps in the middle of a black run
    drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) drive(1, 0, 0, 1, 8'h00, 8'h00, 8'h00);

    // Random video with periodic blanking and occasional enable gaps
    pos = 0;
    for (int i = 0; i < 10000; i++) begin
      bit en;
      en = ($urandom_range(0, 7) != 0);
      drive(en, (pos % 48) < 40, 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      if (en) pos++;
    end

    // Reset in the middle of an active line
    repeat (5) drive(1, 1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_ch0", tmds_ch0_o === 10'h354, {22'd0, tmds_ch0_o}, 32'h354);
    chk("async_rst_ch1", tmds_ch1_o === 10'h354, {22'd0, tmds_ch1_o}, 32'h354);
    chk("async_rst_ch2", tmds_ch2_o === 10'h354, {22'd0, tmds_ch2_o}, 32'h354);
    chk("async_rst_de",  de_o === 1'b0, {31'd0, de_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    clk_en_i = 1'b0;
    rst_ni   = 1'b1;
    seed_after_reset();
    repeat (6) drive(1, 1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (3) drive(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);

    @(negedge clk_i);
    clk_en_i = 1'b0;
    @(posedge clk_i);
    #2;
    chk("drain", q_exp.size() == 1, q_exp.size(), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
